phase_timer: RTL
================

PHASE_TIMER -- requirements
Module: phase_timer

Interface
REQ-001 Parameter CNT_W, default 16, SHALL set the width of each phase duration and of the remaining-count output.
REQ-002 Parameter NUM_PHASES, default 4, SHALL set the number of phases; PH_W = max(1, clog2(NUM_PHASES)).
REQ-003 Parameter PRESCALE, default 1, SHALL set the clk cycles per count tick (1 = tick every cycle; values below 1 are illegal).
REQ-004 clk  input  1  sole clock; all state SHALL update on its rising edge.
REQ-005 Timer_RST  input  1  SHALL be the asynchronous, active-high reset.
REQ-006 start  input  1  sampled pulse; begins a sequence when idle.
REQ-007 start_phase  input  PH_W  first phase of the sequence.
REQ-008 auto_adv  input  1  1 = chain phases to the last; 0 = run one phase only; sampled with start.
REQ-009 pause  input  1  level; freezes timing while high.
REQ-010 abort  input  1  sampled pulse; cancels any activity.
REQ-011 durations  input  NUM_PHASES*CNT_W  phase k duration in ticks at bits [k*CNT_W +: CNT_W].
REQ-012 phase  output  PH_W  current phase index.
REQ-013 remaining  output  CNT_W  ticks left in the current phase.
REQ-014 busy  output  1  high in RUN or PAUSE.
REQ-015 phase_done  output  1  one-cycle pulse at the end of each phase.
REQ-016 all_done  output  1  one-cycle pulse at the end of a sequence.

Function
REQ-017 The FSM SHALL have the states IDLE, RUN and PAUSE; busy = (state != IDLE).
REQ-018 IDLE with start=1 and abort=0: the block SHALL latch phase = min(start_phase, NUM_PHASES-1), latch auto_adv, load remaining = durations[phase], clear the prescaler and enter RUN.
REQ-019 start SHALL be ignored in RUN and PAUSE.
REQ-020 RUN: the prescaler SHALL count 0..PRESCALE-1 and wrap; each wrap is one tick and SHALL decrement remaining by 1.
REQ-021 A phase SHALL complete on the tick that takes remaining from 1 to 0; phase_done SHALL be high in the following cycle.
REQ-022 A phase of duration D started at edge E SHALL assert phase_done exactly D*PRESCALE cycles after E.
REQ-023 Duration 0 SHALL complete on the first cycle after load, without consuming a tick.
REQ-024 On completion with latched auto_adv=1 and phase < NUM_PHASES-1: phase SHALL increment, remaining SHALL load the next duration, the prescaler SHALL clear, and the state SHALL stay RUN with no idle cycle.
REQ-025 On completion otherwise (last phase, or auto_adv=0): all_done SHALL pulse together with phase_done, the state SHALL return to IDLE, remaining SHALL equal 0, and phase SHALL hold.
REQ-026 RUN with pause=1 SHALL enter PAUSE on that edge, holding the prescaler and remaining; that edge SHALL produce no tick.
REQ-027 PAUSE with pause=0 SHALL return to RUN, and the prescaler SHALL resume from its held value.
REQ-028 If pause and a completing tick coincide, pause SHALL win; completion SHALL occur after resume.
REQ-029 abort SHALL have priority over start, pause and completion.
REQ-030 abort SHALL force IDLE, remaining=0 and prescaler=0, and SHALL suppress phase_done and all_done for that cycle.
REQ-031 Changes to durations SHALL take effect only when a duration is loaded.
REQ-032 remaining SHALL never wrap below 0.

Reset
REQ-033 Timer_RST high SHALL immediately force: state=IDLE, phase=0, remaining=0, prescaler=0, busy=0, phase_done=0, all_done=0, latched auto_adv=0.
REQ-034 Reset asserted mid-sequence SHALL discard the sequence; after release the block SHALL wait in IDLE for start.

Structure
REQ-035 Package phase_timer_pkg SHALL hold the FSM state typedef (IDLE/RUN/PAUSE) and the PH_W/prescaler-width helper functions.
REQ-036 The prescaler SHALL be a sub-module tick_prescaler (ports: clk, Timer_RST, clear, enable, tick).

Verification
REQ-037 PRESCALE=4, durations[0]=3, auto_adv=0, start_phase=0: start -> phase_done and all_done high exactly 12 cycles later, busy low after.
REQ-038 PRESCALE=1, durations={2,0,5,1}, auto_adv=1, start_phase=0: phase_done at +2,+3,+8,+9 cycles; all_done only at +9; phase steps 0,1,2,3.
REQ-039 PRESCALE=2, duration 4: pause high for 7 cycles mid-phase -> phase_done delayed by exactly 7 cycles (at +15) and remaining frozen throughout the pause.
REQ-040 Abort asserted 1 cycle before the expected phase_done -> no done pulse, remaining=0, IDLE; a start in the same cycle is ignored.
REQ-041 Timer_RST pulsed asynchronously between clock edges mid-phase -> outputs zero immediately; after release, a start with start_phase=7 and NUM_PHASES=4 runs phase 3.
REQ-042 start held high during RUN -> no reload; sequence timing is unchanged.

Source files
------------

// File: rtl/phase_timer_pkg.sv
// ============================================================================
// Module   : phase_timer_pkg
// Brief    : Shared FSM state encoding and width helpers for the phase timer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package phase_timer_pkg;

    typedef logic [1:0] state_t;

    localparam state_t c_ST_IDLE  = 2'd0;
    localparam state_t c_ST_RUN   = 2'd1;
    localparam state_t c_ST_PAUSE = 2'd2;

    function automatic int ph_width(input int num_phases);
        return (num_phases > 1) ? $clog2(num_phases) : 1;
    endfunction

    function automatic int pre_width(input int prescale);
        return (prescale > 1) ? $clog2(prescale) : 1;
    endfunction

    function automatic int clamp_phase(input int sp, input int num_phases);
        return (sp > num_phases - 1) ? num_phases - 1 : sp;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tick_prescaler.sv
// ============================================================================
// Module   : tick_prescaler
// Brief    : Free-running 0..PRESCALE-1 counter emitting a tick on each wrap.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tick_prescaler
    import phase_timer_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic Timer_RST,
    input  logic clear,
    input  logic enable,
    output logic tick
);

    localparam int                 c_W   = pre_width(PRESCALE);
    localparam logic [c_W-1:0]     c_MAX = c_W'(PRESCALE - 1);

    logic [c_W-1:0] r_cnt;
    logic           w_wrap;

    assign w_wrap = (r_cnt == c_MAX);
    assign tick   = enable && w_wrap;

    // clear beats enable so a reload always restarts a full tick period
    always_ff @(posedge clk or posedge Timer_RST) begin
        if (Timer_RST) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (enable) begin
            r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/phase_timer.sv
// ============================================================================
// Module   : phase_timer
// Brief    : Multi-phase countdown sequencer with pause, abort and auto-advance.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module phase_timer
    import phase_timer_pkg::*;
#(
    parameter  int CNT_W      = 16,
    parameter  int NUM_PHASES = 4,
    parameter  int PRESCALE   = 1,
    localparam int PH_W       = ph_width(NUM_PHASES)
) (
    input  logic                        clk,
    input  logic                        Timer_RST,
    input  logic                        start,
    input  logic [PH_W-1:0]             start_phase,
    input  logic                        auto_adv,
    input  logic                        pause,
    input  logic                        abort,
    input  logic [NUM_PHASES*CNT_W-1:0] durations,
    output logic [PH_W-1:0]             phase,
    output logic [CNT_W-1:0]            remaining,
    output logic                        busy,
    output logic                        phase_done,
    output logic                        all_done
);

    state_t           r_state;
    logic [PH_W-1:0]  r_phase;
    logic [CNT_W-1:0] r_rem;
    logic             r_auto;
    logic             r_pd;
    logic             r_ad;

    logic             w_active;
    logic             w_tick;
    logic             w_complete;
    logic             w_last;
    logic             w_advance;
    logic             w_start;
    logic             w_pclear;
    logic [PH_W-1:0]  w_start_ph;
    logic [PH_W-1:0]  w_load_idx;
    logic [CNT_W-1:0] w_load_dur;

    // The resume edge out of PAUSE counts like a RUN edge, so a pause costs
    // exactly as many cycles as pause was sampled high.
    assign w_active   = (r_state != c_ST_IDLE) && !pause && !abort;
    assign w_complete = w_active && ((r_rem == '0) || (w_tick && (r_rem == CNT_W'(1))));
    assign w_last     = (r_phase == PH_W'(NUM_PHASES - 1));
    assign w_advance  = w_complete && r_auto && !w_last;
    assign w_start    = (r_state == c_ST_IDLE) && start && !abort;
    assign w_pclear   = w_start || w_complete || abort;

    assign w_start_ph = PH_W'(clamp_phase(32'(start_phase), NUM_PHASES));
    assign w_load_idx = w_start ? w_start_ph : r_phase + 1'b1;
    assign w_load_dur = durations[w_load_idx*CNT_W +: CNT_W];

    tick_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk       (clk),
        .Timer_RST (Timer_RST),
        .clear     (w_pclear),
        .enable    (w_active),
        .tick      (w_tick)
    );

    always_ff @(posedge clk or posedge Timer_RST) begin
        if (Timer_RST) begin
            r_state <= c_ST_IDLE;
            r_phase <= '0;
            r_rem   <= '0;
            r_auto  <= 1'b0;
            r_pd    <= 1'b0;
            r_ad    <= 1'b0;
        end else begin
            r_pd <= 1'b0;
            r_ad <= 1'b0;
            if (abort) begin
                r_state <= c_ST_IDLE;
                r_rem   <= '0;
            end else begin
                case (r_state)
                    c_ST_IDLE: begin
                        if (w_start) begin
                            r_phase <= w_start_ph;
                            r_auto  <= auto_adv;
                            r_rem   <= w_load_dur;
                            r_state <= c_ST_RUN;
                        end
                    end
                    c_ST_RUN, c_ST_PAUSE: begin
                        if (pause) begin
                            r_state <= c_ST_PAUSE;
                        end else begin
                            r_state <= c_ST_RUN;
                            if (w_complete) begin
                                r_pd <= 1'b1;
                                if (w_advance) begin
                                    r_phase <= r_phase + 1'b1;
                                    r_rem   <= w_load_dur;
                                end else begin
                                    r_ad    <= 1'b1;
                                    r_rem   <= '0;
                                    r_state <= c_ST_IDLE;
                                end
                            end else if (w_tick) begin
                                r_rem <= r_rem - 1'b1;
                            end
                        end
                    end
                    default: r_state <= c_ST_IDLE;
                endcase
            end
        end
    end

    assign phase      = r_phase;
    assign remaining  = r_rem;
    assign busy       = (r_state != c_ST_IDLE);
    assign phase_done = r_pd;
    assign all_done   = r_ad;

endmodule

`default_nettype wire
